// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared defaults, command encodings and operand-validity codes
//               for the clocked integer ALU. Optional multiplier support is
//               selected with the ALU_MULT_EN macro in the design files.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_CMD_WIDTH = 4;

  // Arithmetic command codes (MODE=1)
  typedef enum logic [3:0] {
    ACMD_ADD     = 4'd0,
    ACMD_SUB     = 4'd1,
    ACMD_ADD_CIN = 4'd2,
    ACMD_SUB_CIN = 4'd3,
    ACMD_INC_A   = 4'd4,
    ACMD_DEC_A   = 4'd5,
    ACMD_INC_B   = 4'd6,
    ACMD_DEC_B   = 4'd7,
    ACMD_CMP     = 4'd8,
    ACMD_MUL_INC = 4'd9,
    ACMD_MUL_SHL = 4'd10
  } arith_cmd_e;

  // Logical command codes (MODE=0)
  typedef enum logic [3:0] {
    LCMD_AND    = 4'd0,
    LCMD_NAND   = 4'd1,
    LCMD_OR     = 4'd2,
    LCMD_NOR    = 4'd3,
    LCMD_XOR    = 4'd4,
    LCMD_XNOR   = 4'd5,
    LCMD_NOT_A  = 4'd6,
    LCMD_NOT_B  = 4'd7,
    LCMD_SHR1_A = 4'd8,
    LCMD_SHL1_A = 4'd9,
    LCMD_SHR1_B = 4'd10,
    LCMD_SHL1_B = 4'd11,
    LCMD_ROL    = 4'd12,
    LCMD_ROR    = 4'd13
  } logic_cmd_e;

  // INP_VALID encodings; also used as the "operands needed" mask of a command
  localparam logic [1:0] IV_NONE = 2'b00;
  localparam logic [1:0] IV_A    = 2'b01;
  localparam logic [1:0] IV_B    = 2'b10;
  localparam logic [1:0] IV_AB   = 2'b11;

  // True when every operand the command needs is flagged valid
  function automatic logic operands_ok(input logic [1:0] need, input logic [1:0] valid);
    return (valid & need) == need;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mult.sv
// ============================================================================
// Module      : alu_mult
// Description : Registered multiplier front end. Captures operands and the
//               multiply flavour when a multiply is accepted, and presents
//               the product of the captured operands one enabled edge later.
//               Only instantiated when ALU_MULT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mult
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ce_i,
  input  logic               start_i,
  input  logic               sel_shl_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               valid_o,
  output logic [2*WIDTH-1:0] product_o
);

  logic               valid_q, valid_d;
  logic               sel_q, sel_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH:0]     inc_a, inc_b;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod_inc, prod_shl;

  // Capture on an accepted multiply; any other enabled command drops the pending one
  always_comb begin
    valid_d = valid_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    if (ce_i) begin
      valid_d = start_i;
      if (start_i) begin
        sel_d = sel_shl_i;
        a_d   = a_i;
        b_d   = b_i;
      end
    end
  end

  // Capture registers; reset aborts any pending multiply
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      sel_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      valid_q <= valid_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Products of the captured operands, truncated to 2*WIDTH bits
  always_comb begin
    inc_a     = {1'b0, a_q} + {{WIDTH{1'b0}}, 1'b1};
    inc_b     = {1'b0, b_q} + {{WIDTH{1'b0}}, 1'b1};
    ext_a     = {{(WIDTH-1){1'b0}}, inc_a};
    ext_b     = {{(WIDTH-1){1'b0}}, inc_b};
    prod_inc  = ext_a * ext_b;
    prod_shl  = {{WIDTH{1'b0}}, a_q[WIDTH-2:0], 1'b0} * {{WIDTH{1'b0}}, b_q};
    product_o = sel_q ? prod_shl : prod_inc;
  end

  assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/alu_design.sv
// ============================================================================
// Module      : alu_design
// Description : Clocked integer ALU with registered result and flags.
//               Single-cycle arithmetic/logic; optional 2-cycle multiply
//               commands (MODE=1, CMD 9/10) enabled by defining ALU_MULT_EN.
//               CMD_WIDTH must be at least 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_design
  import alu_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CMD_WIDTH = DEF_CMD_WIDTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     OPA,
  input  logic [WIDTH-1:0]     OPB,
  input  logic [1:0]           INP_VALID,
  input  logic                 CE,
  input  logic                 MODE,
  input  logic                 CIN,
  input  logic [CMD_WIDTH-1:0] CMD,
  output logic [2*WIDTH-1:0]   RES,
  output logic                 COUT,
  output logic                 OFLOW,
  output logic                 G,
  output logic                 E,
  output logic                 L,
  output logic                 ERR
);

  localparam int SHW = $clog2(WIDTH);

  logic [3:0]         cmd4;
  logic               cmd_hi_zero;
  logic [SHW-1:0]     rot_amt;
  logic [WIDTH:0]     ext;
  logic [2*WIDTH-1:0] rot;
  logic [1:0]         need;
  logic               cmd_defined, rot_bad, cmd_err;
  logic [2*WIDTH-1:0] op_res;
  logic               op_cout, op_oflow, op_g, op_e, op_l;
  logic               mult_start, mul_valid;
  logic [2*WIDTH-1:0] mul_product;
`ifdef ALU_MULT_EN
  logic               mult_cmd;
`endif

  logic [2*WIDTH-1:0] res_q, res_d;
  logic               cout_q, cout_d, oflow_q, oflow_d;
  logic               g_q, g_d, e_q, e_d, l_q, l_d, err_q, err_d;

  // Codes wider than 4 bits are only legal when the upper bits are zero
  assign cmd4        = CMD[3:0];
  assign cmd_hi_zero = ((CMD >> 4) == '0);
  assign rot_amt     = OPB[SHW-1:0];

  // Decode the command and compute its single-cycle result and flags
  always_comb begin
    ext         = '0;
    rot         = '0;
    need        = IV_AB;
    cmd_defined = 1'b1;
    rot_bad     = 1'b0;
    op_res      = '0;
    op_cout     = 1'b0;
    op_oflow    = 1'b0;
    op_g        = 1'b0;
    op_e        = 1'b0;
    op_l        = 1'b0;
`ifdef ALU_MULT_EN
    mult_cmd    = 1'b0;
`endif
    if (MODE) begin
      case (cmd4)
        ACMD_ADD:     begin ext = {1'b0, OPA} + {1'b0, OPB}; op_cout = ext[WIDTH];
                            op_res = {{(WIDTH-1){1'b0}}, ext}; end
        ACMD_SUB:     begin ext = {1'b0, OPA} - {1'b0, OPB}; op_oflow = ext[WIDTH];
                            op_res = {{WIDTH{1'b0}}, ext[WIDTH-1:0]}; end
        ACMD_ADD_CIN: begin ext = {1'b0, OPA} + {1'b0, OPB} + {{WIDTH{1'b0}}, CIN};
                            op_cout = ext[WIDTH]; op_res = {{(WIDTH-1){1'b0}}, ext}; end
        ACMD_SUB_CIN: begin ext = {1'b0, OPA} - {1'b0, OPB} - {{WIDTH{1'b0}}, CIN};
                            op_oflow = ext[WIDTH]; op_res = {{WIDTH{1'b0}}, ext[WIDTH-1:0]}; end
        ACMD_INC_A:   begin need = IV_A; ext = {1'b0, OPA} + {{WIDTH{1'b0}}, 1'b1};
                            op_cout = ext[WIDTH]; op_res = {{(WIDTH-1){1'b0}}, ext}; end
        ACMD_DEC_A:   begin need = IV_A; ext = {1'b0, OPA} - {{WIDTH{1'b0}}, 1'b1};
                            op_oflow = ext[WIDTH]; op_res = {{WIDTH{1'b0}}, ext[WIDTH-1:0]}; end
        ACMD_INC_B:   begin need = IV_B; ext = {1'b0, OPB} + {{WIDTH{1'b0}}, 1'b1};
                            op_cout = ext[WIDTH]; op_res = {{(WIDTH-1){1'b0}}, ext}; end
        ACMD_DEC_B:   begin need = IV_B; ext = {1'b0, OPB} - {{WIDTH{1'b0}}, 1'b1};
                            op_oflow = ext[WIDTH]; op_res = {{WIDTH{1'b0}}, ext[WIDTH-1:0]}; end
        ACMD_CMP:     begin op_g = (OPA > OPB); op_e = (OPA == OPB); op_l = (OPA < OPB); end
`ifdef ALU_MULT_EN
        ACMD_MUL_INC,
        ACMD_MUL_SHL: mult_cmd = 1'b1;
`endif
        default:      cmd_defined = 1'b0;
      endcase
    end else begin
      case (cmd4)
        LCMD_AND:    op_res = {{WIDTH{1'b0}}, OPA & OPB};
        LCMD_NAND:   op_res = {{WIDTH{1'b0}}, ~(OPA & OPB)};
        LCMD_OR:     op_res = {{WIDTH{1'b0}}, OPA | OPB};
        LCMD_NOR:    op_res = {{WIDTH{1'b0}}, ~(OPA | OPB)};
        LCMD_XOR:    op_res = {{WIDTH{1'b0}}, OPA ^ OPB};
        LCMD_XNOR:   op_res = {{WIDTH{1'b0}}, ~(OPA ^ OPB)};
        LCMD_NOT_A:  begin need = IV_A; op_res = {{WIDTH{1'b0}}, ~OPA}; end
        LCMD_NOT_B:  begin need = IV_B; op_res = {{WIDTH{1'b0}}, ~OPB}; end
        LCMD_SHR1_A: begin need = IV_A; op_res = {{WIDTH{1'b0}}, 1'b0, OPA[WIDTH-1:1]}; end
        LCMD_SHL1_A: begin need = IV_A; op_res = {{WIDTH{1'b0}}, OPA[WIDTH-2:0], 1'b0}; end
        LCMD_SHR1_B: begin need = IV_B; op_res = {{WIDTH{1'b0}}, 1'b0, OPB[WIDTH-1:1]}; end
        LCMD_SHL1_B: begin need = IV_B; op_res = {{WIDTH{1'b0}}, OPB[WIDTH-2:0], 1'b0}; end
        LCMD_ROL:    begin rot_bad = ((OPB >> SHW) != '0); rot = {OPA, OPA} << rot_amt;
                           op_res = {{WIDTH{1'b0}}, rot[2*WIDTH-1:WIDTH]}; end
        LCMD_ROR:    begin rot_bad = ((OPB >> SHW) != '0); rot = {OPA, OPA} >> rot_amt;
                           op_res = {{WIDTH{1'b0}}, rot[WIDTH-1:0]}; end
        default:     cmd_defined = 1'b0;
      endcase
    end
    cmd_err = !cmd_hi_zero || !cmd_defined || rot_bad || !operands_ok(need, INP_VALID);
  end

`ifdef ALU_MULT_EN
  assign mult_start = mult_cmd && !cmd_err;

  alu_mult #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk_i     (CLK),
    .rst_ni    (RST),
    .ce_i      (CE),
    .start_i   (mult_start),
    .sel_shl_i (cmd4 == ACMD_MUL_SHL),
    .a_i       (OPA),
    .b_i       (OPB),
    .valid_o   (mul_valid),
    .product_o (mul_product)
  );
`else
  assign mult_start  = 1'b0;
  assign mul_valid   = 1'b0;
  assign mul_product = '0;
`endif

  // Choose what the output registers load: hold, multiply result, error or new result
  always_comb begin
    res_d   = res_q;
    cout_d  = cout_q;
    oflow_d = oflow_q;
    g_d     = g_q;
    e_d     = e_q;
    l_d     = l_q;
    err_d   = err_q;
    if (CE) begin
      if (mult_start) begin
        // A multiply in flight lands now; otherwise the previous outputs hold
        if (mul_valid) begin
          res_d   = mul_product;
          cout_d  = 1'b0;
          oflow_d = 1'b0;
          g_d     = 1'b0;
          e_d     = 1'b0;
          l_d     = 1'b0;
          err_d   = 1'b0;
        end
      end else if (cmd_err) begin
        res_d   = '0;
        cout_d  = 1'b0;
        oflow_d = 1'b0;
        g_d     = 1'b0;
        e_d     = 1'b0;
        l_d     = 1'b0;
        err_d   = 1'b1;
      end else begin
        res_d   = op_res;
        cout_d  = op_cout;
        oflow_d = op_oflow;
        g_d     = op_g;
        e_d     = op_e;
        l_d     = op_l;
        err_d   = 1'b0;
      end
    end
  end

  // Output registers with asynchronous active-low clear
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      res_q   <= '0;
      cout_q  <= 1'b0;
      oflow_q <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      l_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      res_q   <= res_d;
      cout_q  <= cout_d;
      oflow_q <= oflow_d;
      g_q     <= g_d;
      e_q     <= e_d;
      l_q     <= l_d;
      err_q   <= err_d;
    end
  end

  assign RES   = res_q;
  assign COUT  = cout_q;
  assign OFLOW = oflow_q;
  assign G     = g_q;
  assign E     = e_q;
  assign L     = l_q;
  assign ERR   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_design.sv
// ============================================================================
// Module      : tb_alu_design
// Description : Self-checking bench for alu_design. Directed vectors with
//               literal expectations plus a per-cycle comparison against a
//               behavioural model. Multiply checks follow ALU_MULT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_design;
  import alu_pkg::*;

  localparam int W     = DEF_WIDTH;
  localparam int MASK  = (1 << W) - 1;
  localparam int MASK2 = (1 << (2 * W)) - 1;

  logic           CLK = 1'b0;
  logic           RST = 1'b0;
  logic [W-1:0]   OPA = '0;
  logic [W-1:0]   OPB = '0;
  logic [1:0]     INP_VALID = 2'b00;
  logic           CE = 1'b0;
  logic           MODE = 1'b0;
  logic           CIN = 1'b0;
  logic [3:0]     CMD = 4'd0;
  logic [2*W-1:0] RES;
  logic           COUT, OFLOW, G, E, L, ERR;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  alu_design #(.WIDTH(W), .CMD_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .OPA(OPA), .OPB(OPB), .INP_VALID(INP_VALID),
    .CE(CE), .MODE(MODE), .CIN(CIN), .CMD(CMD),
    .RES(RES), .COUT(COUT), .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  typedef struct {
    int res;
    bit cout, oflow, g, e, l, err, mul;
  } out_t;

  function automatic out_t model_cmd(bit mode, int cmd, int a, int b, bit cin, int iv);
    out_t o;
    int   need;
    bit   known;
    o     = '{default: 0};
    need  = 3;
    known = 1'b1;
    if (mode) begin
      case (cmd)
        0: begin o.res = a + b; o.cout = o.res > MASK; end
        1: begin o.oflow = a < b; o.res = (a - b) & MASK; end
        2: begin o.res = a + b + int'(cin); o.cout = o.res > MASK; end
        3: begin o.oflow = a < b + int'(cin); o.res = (a - b - int'(cin)) & MASK; end
        4: begin need = 1; o.res = a + 1; o.cout = o.res > MASK; end
        5: begin need = 1; o.oflow = (a == 0); o.res = (a - 1) & MASK; end
        6: begin need = 2; o.res = b + 1; o.cout = o.res > MASK; end
        7: begin need = 2; o.oflow = (b == 0); o.res = (b - 1) & MASK; end
        8: begin o.g = a > b; o.e = a == b; o.l = a < b; end
`ifdef ALU_MULT_EN
        9:  begin o.mul = 1'b1; o.res = ((a + 1) * (b + 1)) & MASK2; end
        10: begin o.mul = 1'b1; o.res = (((a * 2) & MASK) * b) & MASK2; end
`endif
        default: known = 1'b0;
      endcase
    end else begin
      case (cmd)
        0:  o.res = a & b;
        1:  o.res = ~(a & b) & MASK;
        2:  o.res = a | b;
        3:  o.res = ~(a | b) & MASK;
        4:  o.res = a ^ b;
        5:  o.res = ~(a ^ b) & MASK;
        6:  begin need = 1; o.res = ~a & MASK; end
        7:  begin need = 2; o.res = ~b & MASK; end
        8:  begin need = 1; o.res = a / 2; end
        9:  begin need = 1; o.res = (a * 2) & MASK; end
        10: begin need = 2; o.res = b / 2; end
        11: begin need = 2; o.res = (b * 2) & MASK; end
        12: if (b >= W) known = 1'b0; else o.res = ((a << b) | (a >> (W - b))) & MASK;
        13: if (b >= W) known = 1'b0; else o.res = ((a >> b) | (a << (W - b))) & MASK;
        default: known = 1'b0;
      endcase
    end
    if (!known || ((iv & need) != need)) begin
      o     = '{default: 0};
      o.err = 1'b1;
    end
    return o;
  endfunction

  out_t exp_o    = '{default: 0};
  out_t mr       = '{default: 0};
  bit   pend     = 1'b0;
  int   pend_res = 0;

  // Expected outputs: one-cycle results, or a one-deep multiply pipeline
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      exp_o = '{default: 0};
      pend  = 1'b0;
    end else if (CE) begin
      mr = model_cmd(MODE, int'(CMD), int'(OPA), int'(OPB), CIN, int'(INP_VALID));
      if (mr.mul) begin
        if (pend) begin
          exp_o     = '{default: 0};
          exp_o.res = pend_res;
        end
        pend     = 1'b1;
        pend_res = mr.res;
      end else begin
        exp_o = mr;
        pend  = 1'b0;
      end
    end
  end

  // Compare DUT against the model on every falling edge
  always @(negedge CLK) begin
    if (chk_en) begin
      logic [2*W-1:0] er;
      er = exp_o.res[2*W-1:0];
      checks++;
      if (RES !== er || COUT !== exp_o.cout || OFLOW !== exp_o.oflow || G !== exp_o.g ||
          E !== exp_o.e || L !== exp_o.l || ERR !== exp_o.err) begin
        errors++;
        $display("FAIL model @%0t: got res=%0h c=%b o=%b g=%b e=%b l=%b err=%b, want res=%0h c=%b o=%b g=%b e=%b l=%b err=%b",
                 $time, RES, COUT, OFLOW, G, E, L, ERR,
                 er, exp_o.cout, exp_o.oflow, exp_o.g, exp_o.e, exp_o.l, exp_o.err);
      end
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic expect_out(input string name, input int res, input bit c, input bit o,
                            input bit g, input bit e, input bit l, input bit err);
    logic [2*W-1:0] er;
    er = res[2*W-1:0];
    checks++;
    if (RES !== er || COUT !== c || OFLOW !== o || G !== g || E !== e || L !== l || ERR !== err) begin
      errors++;
      $display("FAIL %s: got res=%0h c=%b o=%b g=%b e=%b l=%b err=%b, want res=%0h c=%b o=%b g=%b e=%b l=%b err=%b",
               name, RES, COUT, OFLOW, G, E, L, ERR, er, c, o, g, e, l, err);
    end
  endtask

  task automatic drive(input bit mode, input int cmd, input int a, input int b,
                       input bit cin, input int iv, input bit ce);
    @(negedge CLK);
    MODE      = mode;
    CMD       = cmd[3:0];
    OPA       = a[W-1:0];
    OPB       = b[W-1:0];
    CIN       = cin;
    INP_VALID = iv[1:0];
    CE        = ce;
    @(posedge CLK);
    #1;
  endtask

  task automatic vec(input string name, input bit mode, input int cmd, input int a, input int b,
                     input bit cin, input int iv, input int eres, input bit ec, input bit eo,
                     input bit eg, input bit ee, input bit el, input bit eerr);
    drive(mode, cmd, a, b, cin, iv, 1'b1);
    expect_out(name, eres, ec, eo, eg, ee, el, eerr);
  endtask

  // Assert reset in the middle of the high phase, check the clear is immediate, then release
  task automatic mid_reset(input string name);
    #2;
    RST = 1'b0;
    #1;
    expect_out(name, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    CE  = 1'b0;
    RST = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a, b, cin_i;

    // Reset held while clocking with a valid command presented
    CE = 1'b1; MODE = 1'b1; CMD = 4'd0; OPA = 8'd3; OPB = 8'd4; INP_VALID = 2'b11;
    repeat (2) @(posedge CLK);
    #1;
    expect_out("reset_hold", 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    @(negedge CLK);
    CE  = 1'b0;
    RST = 1'b1;

    //   name          mode cmd  A     B     cin iv   res    c o g e l err
    vec("add_3_4",     1, 0,  3,    4,    0, 3,   7,     0,0,0,0,0,0);
    vec("add_255_1",   1, 0,  255,  1,    0, 3,   'h100, 1,0,0,0,0,0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1, 9 + i, 2, 1'b1, 3, 1'b0);
      expect_out("ce_hold", 'h100, 1, 0, 0, 0, 0, 0);
    end
    vec("sub_5_7",     1, 1,  5,    7,    0, 3,   'hFE,  0,1,0,0,0,0);
    vec("add_cin",     1, 2,  10,   5,    1, 3,   16,    0,0,0,0,0,0);
    vec("sub_cin",     1, 3,  3,    3,    1, 3,   'hFF,  0,1,0,0,0,0);
    vec("inc_b_ff",    1, 6,  0,    255,  0, 2,   'h100, 1,0,0,0,0,0);
    vec("dec_a_0",     1, 5,  0,    77,   0, 1,   'hFF,  0,1,0,0,0,0);
    vec("cmp_eq",      1, 8,  9,    9,    0, 3,   0,     0,0,0,1,0,0);
    vec("cmp_gt",      1, 8,  10,   3,    0, 3,   0,     0,0,1,0,0,0);
    vec("and",         0, 0,  'hF0, 'h3C, 0, 3,   'h30,  0,0,0,0,0,0);
    vec("rol_81_1",    0, 12, 'h81, 1,    0, 3,   'h03,  0,0,0,0,0,0);
    vec("ror_bad",     0, 13, 'h01, 'h10, 0, 3,   0,     0,0,0,0,0,1);
    vec("add_iv01",    1, 0,  1,    2,    0, 1,   0,     0,0,0,0,0,1);
    vec("cmd15",       1, 15, 1,    2,    0, 3,   0,     0,0,0,0,0,1);
    vec("iv00",        0, 6,  1,    2,    0, 0,   0,     0,0,0,0,0,1);
    vec("not_a",       0, 6,  'h0F, 0,    0, 1,   'hF0,  0,0,0,0,0,0);
    vec("shl1_b",      0, 11, 0,    'h81, 0, 2,   'h02,  0,0,0,0,0,0);
    mid_reset("reset_async");
    vec("post_reset",  1, 0,  1,    1,    0, 3,   2,     0,0,0,0,0,0);

`ifdef ALU_MULT_EN
    vec("mul_capture", 1, 9,  3,    4,    0, 3,   2,     0,0,0,0,0,0);
    vec("mul_inc",     1, 10, 3,    4,    0, 3,   20,    0,0,0,0,0,0);
    vec("mul_shl",     1, 10, 3,    4,    0, 3,   24,    0,0,0,0,0,0);
    vec("mul_discard", 0, 0,  'hF0, 'h3C, 0, 3,   'h30,  0,0,0,0,0,0);
    vec("mul_fresh",   1, 9,  0,    0,    0, 3,   'h30,  0,0,0,0,0,0);
    drive(1'b1, 9, 7, 7, 1'b0, 3, 1'b0);
    drive(1'b0, 0, 7, 7, 1'b0, 3, 1'b0);
    expect_out("mul_freeze", 'h30, 0, 0, 0, 0, 0, 0);
    vec("mul_thaw",    1, 9,  1,    1,    0, 3,   1,     0,0,0,0,0,0);
    mid_reset("mul_reset");
    vec("mul_aborted", 1, 9,  2,    2,    0, 3,   0,     0,0,0,0,0,0);
    vec("mul_9",       1, 9,  255,  255,  0, 3,   9,     0,0,0,0,0,0);
    vec("mul_wrap",    1, 10, 'h81, 3,    0, 3,   0,     0,0,0,0,0,0);
    vec("mul_shl_tr",  1, 9,  0,    0,    0, 3,   6,     0,0,0,0,0,0);
    vec("mul_iv01",    1, 9,  1,    1,    0, 1,   0,     0,0,0,0,0,1);
`else
    vec("mul_off_9",   1, 9,  3,    4,    0, 3,   0,     0,0,0,0,0,1);
    vec("mul_off_ok",  1, 0,  3,    4,    0, 3,   7,     0,0,0,0,0,0);
    vec("mul_off_10",  1, 10, 3,    4,    0, 3,   0,     0,0,0,0,0,1);
`endif

    // Sweep every code in both modes under each validity pattern; the model checks each cycle
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 16; c++) begin
        for (int iv = 0; iv < 4; iv++) begin
          a     = (c * 37 + iv * 11 + m * 5) & MASK;
          b     = iv[0] ? ((c * 29 + iv * 3) & MASK) : ((c + iv) & 7);
          cin_i = (c ^ iv) & 1;
          drive(m[0], c, a, b, cin_i[0], iv, 1'b1);
        end
      end
    end

    repeat (2) @(negedge CLK);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
